// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift_sequencer block.
// The optional SHIFT_SEQ_EARLY_EXIT_EN build uses early_exit() below.
package shift_seq_pkg;

  localparam int SHIFT_SEQ_DATA_W   = 8;
  localparam int SHIFT_SEQ_AMT_W    = 5;
  localparam int SHIFT_SEQ_STEP_W   = 3;
  localparam int SHIFT_SEQ_STEP_MAX = 7;
  localparam int SHIFT_SEQ_PASS_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } shift_seq_state_t;

  // A request whose result is known to be zero needs no shifter passes.
  function automatic logic early_exit(
    input logic [SHIFT_SEQ_DATA_W-1:0] data,
    input logic [SHIFT_SEQ_AMT_W-1:0]  amount
  );
    return (amount >= 5'(SHIFT_SEQ_DATA_W)) || (data == 8'h00);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake plus barrel_shifter side-channel for shift_sequencer.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = SHIFT_SEQ_DATA_W,
  parameter int AMT_W  = SHIFT_SEQ_AMT_W,
  parameter int STEP_W = SHIFT_SEQ_STEP_W
);

  logic                        i_valid;
  logic                        o_ready;
  logic [DATA_W-1:0]           i_data;
  logic [AMT_W-1:0]            i_amount;
  logic [DATA_W-1:0]           o_bs_data;
  logic [STEP_W-1:0]           o_bs_shift_amt;
  logic [DATA_W-1:0]           i_bs_shift_data;
  logic                        o_valid;
  logic                        i_ready;
  logic [DATA_W-1:0]           o_data;
  logic [SHIFT_SEQ_PASS_W-1:0] o_passes;

  modport slave (
    input  i_valid, i_data, i_amount, i_bs_shift_data, i_ready,
    output o_ready, o_bs_data, o_bs_shift_amt, o_valid, o_data, o_passes
  );

  modport master (
    output i_valid, i_data, i_amount, i_bs_shift_data, i_ready,
    input  o_ready, o_bs_data, o_bs_shift_amt, o_valid, o_data, o_passes
  );

endinterface

// File: rtl/shift_sequencer_step_sel.sv
// Per-pass step selection: min(remaining, STEP_MAX) and a flag marking the final pass.
module shift_step_sel
  import shift_seq_pkg::*;
#(
  parameter int AMT_W  = SHIFT_SEQ_AMT_W,
  parameter int STEP_W = SHIFT_SEQ_STEP_W
) (
  input  logic [AMT_W-1:0]  remaining,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  localparam logic [AMT_W-1:0]  STEP_MAX_A = AMT_W'(SHIFT_SEQ_STEP_MAX);
  localparam logic [STEP_W-1:0] STEP_MAX_S = STEP_W'(SHIFT_SEQ_STEP_MAX);

  // Clamp the step; the pass is last when what remains fits in one step.
  always_comb begin
    step = STEP_MAX_S;
    last = 1'b0;
    if (remaining <= STEP_MAX_A) begin
      step = remaining[STEP_W-1:0];
      last = 1'b1;
    end else begin
      step = STEP_MAX_S;
      last = 1'b0;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass sequencer around an external 8-bit barrel_shifter (steps of at most 7).
// Optional build macro: SHIFT_SEQ_EARLY_EXIT_EN (zero results skip all passes).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = SHIFT_SEQ_DATA_W,
  parameter int AMT_W  = SHIFT_SEQ_AMT_W,
  parameter int STEP_W = SHIFT_SEQ_STEP_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  shift_sequencer_if.slave   bus
);

  shift_seq_state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]             work_r, work_nxt_s;
  logic [AMT_W-1:0]              remaining_r, remaining_nxt_s;
  logic [SHIFT_SEQ_PASS_W-1:0]   passes_r, passes_nxt_s;
  logic [STEP_W-1:0]             step_s;
  logic                          last_s;

  shift_step_sel #(
    .AMT_W  (AMT_W),
    .STEP_W (STEP_W)
  ) u_step_sel (
    .remaining (remaining_r),
    .step      (step_s),
    .last      (last_s)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      work_r      <= {DATA_W{1'b0}};
      remaining_r <= {AMT_W{1'b0}};
      passes_r    <= {SHIFT_SEQ_PASS_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      work_r      <= work_nxt_s;
      remaining_r <= remaining_nxt_s;
      passes_r    <= passes_nxt_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s     = state_r;
    work_nxt_s      = work_r;
    remaining_nxt_s = remaining_r;
    passes_nxt_s    = passes_r;
    case (state_r)
      IDLE: begin
        if (bus.i_valid) begin
          work_nxt_s      = bus.i_data;
          remaining_nxt_s = bus.i_amount;
          passes_nxt_s    = {SHIFT_SEQ_PASS_W{1'b0}};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          if (early_exit(bus.i_data, bus.i_amount)) begin
            work_nxt_s      = {DATA_W{1'b0}};
            remaining_nxt_s = {AMT_W{1'b0}};
            state_nxt_s     = HOLD;
          end else if (bus.i_amount != {AMT_W{1'b0}}) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = HOLD;
          end
`else
          if (bus.i_amount != {AMT_W{1'b0}}) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = HOLD;
          end
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // The shifter result for this pass is captured on the same edge.
        work_nxt_s      = bus.i_bs_shift_data;
        remaining_nxt_s = remaining_r - AMT_W'(step_s);
        passes_nxt_s    = passes_r + 3'd1;
        if (last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HOLD: begin
        if (bus.i_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign bus.o_ready        = (state_r == IDLE);
  assign bus.o_valid        = (state_r == HOLD);
  assign bus.o_data         = work_r;
  assign bus.o_passes       = passes_r;
  assign bus.o_bs_data      = work_r;
  assign bus.o_bs_shift_amt = (state_r == RUN) ? step_s : {STEP_W{1'b0}};

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with a behavioural barrel shifter.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] steps_seen [0:7];
  int   n_steps;

  shift_sequencer_if bus ();

  assign bus.i_bs_shift_data = bus.o_bs_data << bus.o_bs_shift_amt;

  shift_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [7:0] d, input logic [4:0] a,
                         output int lat, output logic [7:0] od, output logic [2:0] op);
    int guard;
    guard = 0;
    n_steps = 0;
    while (bus.o_ready !== 1'b1 && guard < 50) begin
      cyc();
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL req_ready_timeout got o_ready=%b want 1", bus.o_ready);
    end
    bus.i_data   = d;
    bus.i_amount = a;
    bus.i_valid  = 1'b1;
    cyc();
    bus.i_valid = 1'b0;
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 20) begin
      if (n_steps < 8) steps_seen[n_steps] = bus.o_bs_shift_amt;
      n_steps++;
      cyc();
      lat++;
    end
    od = bus.o_data;
    op = bus.o_passes;
  endtask

  task automatic drain();
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got rdy=%b vld=%b want 1 0", bus.o_ready, bus.o_valid);
    end
    checks++;
    if (bus.o_data !== 8'h00 || bus.o_passes !== 3'd0) begin
      errors++;
      $display("FAIL reset_result got data=%h passes=%0d want 00 0", bus.o_data, bus.o_passes);
    end
    checks++;
    if (bus.o_bs_data !== 8'h00 || bus.o_bs_shift_amt !== 3'd0) begin
      errors++;
      $display("FAIL reset_bs got bs_data=%h amt=%0d want 00 0", bus.o_bs_data, bus.o_bs_shift_amt);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_zero_amount();
    int lat; logic [7:0] od; logic [2:0] op;
    run_req(8'h81, 5'd0, lat, od, op);
    checks++;
    if (lat !== 1 || od !== 8'h81 || op !== 3'd0 || n_steps !== 0) begin
      errors++;
      $display("FAIL zero_amount got lat=%0d data=%h passes=%0d steps=%0d want 1 81 0 0",
               lat, od, op, n_steps);
    end
    drain();
  endtask

  task automatic test_single_pass();
    int lat; logic [7:0] od; logic [2:0] op;
    run_req(8'h01, 5'd3, lat, od, op);
    checks++;
    if (lat !== 2 || od !== 8'h08 || op !== 3'd1) begin
      errors++;
      $display("FAIL single_3 got lat=%0d data=%h passes=%0d want 2 08 1", lat, od, op);
    end
    checks++;
    if (n_steps !== 1 || steps_seen[0] !== 3'd3) begin
      errors++;
      $display("FAIL single_3_step got n=%0d step=%0d want 1 3", n_steps, steps_seen[0]);
    end
    drain();
    run_req(8'h01, 5'd7, lat, od, op);
    checks++;
    if (lat !== 2 || od !== 8'h80 || op !== 3'd1) begin
      errors++;
      $display("FAIL single_7 got lat=%0d data=%h passes=%0d want 2 80 1", lat, od, op);
    end
    drain();
    run_req(8'hFF, 5'd5, lat, od, op);
    checks++;
    if (lat !== 2 || od !== 8'hE0 || op !== 3'd1) begin
      errors++;
      $display("FAIL single_ff5 got lat=%0d data=%h passes=%0d want 2 e0 1", lat, od, op);
    end
    drain();
  endtask

  task automatic test_multi_pass();
    int lat; logic [7:0] od; logic [2:0] op;
    run_req(8'h03, 5'd9, lat, od, op);
    checks++;
    if (od !== 8'h00 || op !== (EE ? 3'd0 : 3'd2) || lat !== (EE ? 1 : 3)) begin
      errors++;
      $display("FAIL multi_9 got lat=%0d data=%h passes=%0d want %0d 00 %0d",
               lat, od, op, EE ? 1 : 3, EE ? 0 : 2);
    end
    checks++;
    if (!EE && (n_steps !== 2 || steps_seen[0] !== 3'd7 || steps_seen[1] !== 3'd2)) begin
      errors++;
      $display("FAIL multi_9_steps got n=%0d s0=%0d s1=%0d want 2 7 2",
               n_steps, steps_seen[0], steps_seen[1]);
    end
    drain();
    run_req(8'h01, 5'd31, lat, od, op);
    checks++;
    if (od !== 8'h00 || op !== (EE ? 3'd0 : 3'd5) || lat !== (EE ? 1 : 6)) begin
      errors++;
      $display("FAIL multi_31 got lat=%0d data=%h passes=%0d want %0d 00 %0d",
               lat, od, op, EE ? 1 : 6, EE ? 0 : 5);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] od; logic [2:0] op;
    run_req(8'h05, 5'd1, lat, od, op);
    checks++;
    if (od !== 8'h0A || op !== 3'd1) begin
      errors++;
      $display("FAIL bp_result got data=%h passes=%0d want 0a 1", od, op);
    end
    bus.i_data   = 8'h77;
    bus.i_amount = 5'd2;
    bus.i_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_data !== 8'h0A) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b data=%h want 1 0 0a",
                 i, bus.o_valid, bus.o_ready, bus.o_data);
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    cyc();
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] od; logic [2:0] op;
    bus.i_data   = 8'h01;
    bus.i_amount = 5'd31;
    bus.i_valid  = 1'b1;
    cyc();
    bus.i_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.o_valid !== EE || bus.o_bs_shift_amt !== (EE ? 3'd0 : 3'd7)) begin
      errors++;
      $display("FAIL rst_pre got vld=%b amt=%0d want %b %0d",
               bus.o_valid, bus.o_bs_shift_amt, EE, EE ? 0 : 7);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 ||
        bus.o_passes !== 3'd0 || bus.o_bs_data !== 8'h00 || bus.o_bs_shift_amt !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b vld=%b data=%h passes=%0d bs=%h amt=%0d want 1 0 00 0 00 0",
               bus.o_ready, bus.o_valid, bus.o_data, bus.o_passes, bus.o_bs_data, bus.o_bs_shift_amt);
    end
    #2;
    rst_n = 1'b1;
    run_req(8'h02, 5'd1, lat, od, op);
    checks++;
    if (lat !== 2 || od !== 8'h04 || op !== 3'd1) begin
      errors++;
      $display("FAIL rst_after got lat=%0d data=%h passes=%0d want 2 04 1", lat, od, op);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] od; logic [2:0] op;
    logic [4:0] amts [0:2];
    logic [7:0] exp_d [0:2];
    logic [2:0] exp_p [0:2];
    amts[0] = 5'd0;  exp_d[0] = 8'h01; exp_p[0] = 3'd0;
    amts[1] = 5'd7;  exp_d[1] = 8'h80; exp_p[1] = 3'd1;
    amts[2] = 5'd14; exp_d[2] = 8'h00; exp_p[2] = EE ? 3'd0 : 3'd2;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_req(8'h01, amts[i], lat, od, op);
      checks++;
      if (od !== exp_d[i] || op !== exp_p[i]) begin
        errors++;
        $display("FAIL b2b%0d got data=%h passes=%0d want %h %0d", i, od, op, exp_d[i], exp_p[i]);
      end
    end
    cyc();
    bus.i_ready = 1'b0;
  endtask

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_data   = 8'h00;
    bus.i_amount = 5'd0;
    bus.i_ready  = 1'b0;
    test_reset();
    test_zero_amount();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing stage wrapped around the 8-bit combinational `barrel_shifter`. It accepts a word and a 5-bit total shift amount (0–31) over a valid/ready handshake. It drives the shifter with successive step amounts of at most 7, captures each shifter output back into a working register, and presents the final result on a valid/ready output. It feeds the shifter's `i_data`/`i_shift_amt` and consumes its `o_shift_data`. The shifter performs a logical left shift, zero-filled.

## Interface
- `DATA_W`, 8, data width; matches `barrel_shifter`.
- `AMT_W`, 5, width of the requested total amount.
- `STEP_W`, 3, width of the per-pass shifter amount; maximum step is 2^STEP_W−1 = 7.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  request accepted when `i_valid && o_ready`.
- `i_data`  in  DATA_W  word to shift.
- `i_amount`  in  AMT_W  total left-shift amount.
- `o_bs_data`  out  DATA_W  to `barrel_shifter.i_data`.
- `o_bs_shift_amt`  out  STEP_W  to `barrel_shifter.i_shift_amt`.
- `i_bs_shift_data`  in  DATA_W  from `barrel_shifter.o_shift_data`.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  result consumed when `o_valid && i_ready`.
- `o_data`  out  DATA_W  result, equal to `i_data << i_amount` truncated to DATA_W.
- `o_passes`  out  3  number of shifter passes used.

## Operation
- States:
  - IDLE: `o_ready`=1.
  - RUN: shifter passes in progress.
  - HOLD: `o_valid`=1.
- IDLE, on accept:
  - Latch `work` ← `i_data`, `remaining` ← `i_amount`, `passes` ← 0.
  - Next state is RUN if `i_amount` ≠ 0, else HOLD.
- RUN, each cycle:
  - `step` = min(`remaining`, 7).
  - Outputs: `o_bs_data` = `work`, `o_bs_shift_amt` = `step`.
  - On the clock edge: `work` ← `i_bs_shift_data`, `remaining` ← `remaining` − `step`, `passes` ← `passes` + 1.
  - Go to HOLD when `remaining` − `step` = 0.
- HOLD:
  - `o_data` = `work` and `o_passes` = `passes`, both stable while `o_valid`=1.
  - On `i_ready`, go to IDLE.
  - No accept is possible in the same cycle as the output handshake.
- Outside RUN: `o_bs_shift_amt` = 0 and `o_bs_data` = `work`.
- Requests presented while not in IDLE are ignored (`o_ready`=0).
- `o_passes` equals ceil(amount/7), range 0–5.

## Timing
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_data`=0, `o_passes`=0, `o_bs_data`=0, `o_bs_shift_amt`=0, `work`=0, `remaining`=0.
- Reset asserted mid-RUN or mid-HOLD:
  - Takes effect immediately (asynchronous); the in-flight result is discarded.
  - First accept is possible on the first rising edge after deassertion.
- Latency from accept edge to `o_valid` high:
  - Amount 0: 1 cycle.
  - Otherwise: ceil(amount/7)+1 cycles, i.e. 2 cycles for amounts 1–7 and 6 cycles for amount 31.
- Throughput: one result per (latency + 1) cycles, plus any backpressure cycles.
- The shifter path is combinational (`o_bs_*` → `i_bs_shift_data`) and must close within one `i_clk` period.

## Configuration
- `SHIFT_SEQ_EARLY_EXIT_EN` defined:
  - On accept, if `i_amount` ≥ DATA_W or `i_data` = 0, go directly to HOLD with `o_data`=0 and `o_passes`=0.
  - Latency is then 1 cycle.
- Undefined: every request runs all ceil(amount/7) passes. The `o_data` value is identical in both builds; only latency and `o_passes` differ.

## Structure
- Package `shift_seq_pkg`:
  - State enum `shift_seq_state_t` (IDLE, RUN, HOLD).
  - Constants `SHIFT_SEQ_DATA_W`, `SHIFT_SEQ_AMT_W`, `SHIFT_SEQ_STEP_W`, `SHIFT_SEQ_STEP_MAX`=7.
- Sub-module `shift_step_sel`: combinational min(`remaining`, STEP_MAX), plus a last-pass flag.
- `barrel_shifter` is instantiated beside this block at the next level up, not inside it.

## Test plan
- Zero amount: `i_data`=0x81, `i_amount`=0 → `o_valid` 1 cycle after accept, `o_data`=0x81, `o_passes`=0, `o_bs_shift_amt` stays 0.
- Single pass:
  - 0x01, amount 3 → one RUN cycle with `o_bs_shift_amt`=3; `o_data`=0x08, `o_passes`=1, `o_valid` 2 cycles after accept.
  - 0x01, amount 7 → `o_data`=0x80.
- Multi-pass: 0x03, amount 9 → steps 7 then 2; `o_data`=0x00, `o_passes`=2.
  - Macro on: `o_passes`=0, `o_valid` after 1 cycle.
  - Also 0xFF, amount 5 → `o_data`=0xE0.
- Backpressure: `i_ready` held low 3 cycles in HOLD → `o_data`/`o_valid` stable, `o_ready`=0, concurrent `i_valid` ignored. `i_ready` high → IDLE next cycle.
- Reset mid-op: 0x01, amount 31; `i_rst_n` pulled low during the 3rd RUN cycle → all outputs take reset values immediately. Request 0x02, amount 1 after release → `o_data`=0x04.
- Back-to-back: three requests, amounts 0, 7, 14 (0x01 each), with `i_ready` tied high → `o_data` 0x01, 0x80, 0x00 in order, `o_passes` 0, 1, 2.
